// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, imem request/ack handshake, one-entry hold buffer and IF/ID register.
// Redirects that arrive while a fetch is outstanding squash that fetch's data when it returns.
module fetch_stage #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    input  logic              stall,
    input  logic              flush,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    output logic              id_valid,
    output logic [31:0]       id_instr,
    output logic [ADDR_W-1:0] id_pc,
    output logic [5:0]        id_op,
    output logic [5:0]        id_funct
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_HOLD   = 2'd1,
        ST_SQUASH = 2'd2
    } state_t;

    state_t            state_r, state_s;
    logic [ADDR_W-1:0] pc_r, pc_s;
    logic [ADDR_W-1:0] saved_target_r, saved_target_s;
    logic [31:0]       hold_instr_r, hold_instr_s;
    logic [ADDR_W-1:0] hold_pc_r, hold_pc_s;
    logic              id_valid_r, id_valid_s;
    logic [31:0]       id_instr_r, id_instr_s;
    logic [ADDR_W-1:0] id_pc_r, id_pc_s;
    logic              req_armed_r;
    logic              ack_s;
    logic [ADDR_W-1:0] target_s;
    logic [ADDR_W-1:0] pc_inc_s;

    // The request stays low for the first cycle after reset so a stale ack cannot be taken.
    assign imem_req  = req_armed_r && !reset && (state_r != ST_HOLD);
    assign imem_addr = pc_r;
    assign ack_s     = imem_ack && imem_req;
    assign target_s  = {branch_target[ADDR_W-1:2], 2'b00};
    assign pc_inc_s  = pc_r + {{(ADDR_W-3){1'b0}}, 3'd4};

    assign id_valid  = id_valid_r;
    assign id_instr  = id_instr_r;
    assign id_pc     = id_pc_r;
    assign id_op     = id_instr_r[31:26];
    assign id_funct  = id_instr_r[5:0];

    // Next-state and datapath decisions for the fetch FSM.
    always_comb begin
        state_s        = state_r;
        pc_s           = pc_r;
        saved_target_s = saved_target_r;
        hold_instr_s   = hold_instr_r;
        hold_pc_s      = hold_pc_r;
        id_valid_s     = id_valid_r;
        id_instr_s     = id_instr_r;
        id_pc_s        = id_pc_r;
        case (state_r)
            ST_RUN: begin
                if (ack_s) begin
                    if (branch_taken) begin
                        pc_s       = target_s;
                        id_valid_s = 1'b0;
                    end else if (!id_valid_r || !stall) begin
                        pc_s = pc_inc_s;
                        if (flush) begin
                            id_valid_s = 1'b0;
                        end else begin
                            id_instr_s = imem_rdata;
                            id_pc_s    = pc_r;
                            id_valid_s = 1'b1;
                        end
                    end else begin
                        pc_s         = pc_inc_s;
                        hold_instr_s = imem_rdata;
                        hold_pc_s    = pc_r;
                        if (flush) begin
                            id_valid_s = 1'b0;
                        end else begin
                            state_s = ST_HOLD;
                        end
                    end
                end else if (branch_taken) begin
                    id_valid_s = 1'b0;
                    if (imem_req) begin
                        saved_target_s = target_s;
                        state_s        = ST_SQUASH;
                    end else begin
                        // Nothing outstanding, so the redirect can be applied directly.
                        pc_s = target_s;
                    end
                end else if (flush || (id_valid_r && !stall)) begin
                    id_valid_s = 1'b0;
                end else begin
                    id_valid_s = id_valid_r;
                end
            end
            ST_HOLD: begin
                if (branch_taken) begin
                    pc_s       = target_s;
                    id_valid_s = 1'b0;
                    state_s    = ST_RUN;
                end else if (flush) begin
                    id_valid_s = 1'b0;
                    state_s    = ST_RUN;
                end else if (!stall) begin
                    id_instr_s = hold_instr_r;
                    id_pc_s    = hold_pc_r;
                    id_valid_s = 1'b1;
                    state_s    = ST_RUN;
                end else begin
                    state_s = ST_HOLD;
                end
            end
            ST_SQUASH: begin
                id_valid_s = 1'b0;
                if (ack_s) begin
                    pc_s    = branch_taken ? target_s : saved_target_r;
                    state_s = ST_RUN;
                end else if (branch_taken) begin
                    saved_target_s = target_s;
                end else begin
                    saved_target_s = saved_target_r;
                end
            end
            default: begin
                state_s    = ST_RUN;
                id_valid_s = 1'b0;
            end
        endcase
    end

    // State and pipeline registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r        <= ST_RUN;
            pc_r           <= RESET_PC;
            saved_target_r <= {ADDR_W{1'b0}};
            hold_instr_r   <= 32'd0;
            hold_pc_r      <= {ADDR_W{1'b0}};
            id_valid_r     <= 1'b0;
            id_instr_r     <= 32'd0;
            id_pc_r        <= {ADDR_W{1'b0}};
            req_armed_r    <= 1'b0;
        end else begin
            state_r        <= state_s;
            pc_r           <= pc_s;
            saved_target_r <= saved_target_s;
            hold_instr_r   <= hold_instr_s;
            hold_pc_r      <= hold_pc_s;
            id_valid_r     <= id_valid_s;
            id_instr_r     <= id_instr_s;
            id_pc_r        <= id_pc_s;
            req_armed_r    <= 1'b1;
        end
    end

endmodule
